// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Posted-write buffer between the CPU data-memory port and a slower data
//   memory. CPU stores are captured in a small FIFO in one cycle and drained
//   to memory over a req/ack handshake. Loads see program order because any
//   still-pending bytes for the loaded word are merged over the memory data.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   MemWrite             CPU store strobe
//   ALUResult            CPU byte address (word address = ALUResult[31:2])
//   WriteData, ByteEn    lane-aligned store data and byte-lane enables
//   ReadData             merged load data (combinational)
//   mem_raddr/mem_rdata  memory read port, same-cycle data
//   mem_req/mem_ack      drain handshake; retire on mem_req & mem_ack
//   mem_addr/wdata/be    head entry presented to memory
//   stall_o              buffer full
//   overflow             sticky: a store was dropped while full
//   count                current occupancy
module dmem_write_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [31:0]      ALUResult,
   input  logic [31:0]      WriteData,
   input  logic [3:0]       ByteEn,
   output logic [31:0]      ReadData,
   output logic [29:0]      mem_raddr,
   input  logic [31:0]      mem_rdata,
   output logic             mem_req,
   output logic [29:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   output logic             stall_o,
   output logic             overflow,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   // Entry storage
   logic [29:0]      addr_q [DEPTH];
   logic [29:0]      addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [3:0]       be_d   [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;

   // Control state
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   logic             full;
   logic             not_empty;
   logic             store_req;
   logic             enq;
   logic             retire;
   logic [31:0]      merged;

   // Byte offset within the word has no role here; loads and stores are lane-aligned.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^ALUResult[1:0];

   assign full      = (count_q == CNT_W'(DEPTH));
   assign not_empty = (count_q != '0);
   assign store_req = MemWrite && (ByteEn != 4'b0000);
   assign retire    = not_empty && mem_ack;
   // A retire frees the head slot at the same edge, so a full buffer can still accept.
   assign enq       = store_req && (!full || retire);

   // Next-state for control and storage
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      data_d     = data_q;
      be_d       = be_q;

      if (retire) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end

      if (enq) begin
         addr_d[tail_q]  = ALUResult[31:2];
         data_d[tail_q]  = WriteData;
         be_d[tail_q]    = ByteEn;
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end

      unique case ({enq, retire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (store_req && full && !retire) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         valid_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         be_q       <= be_d;
      end
   end

   // Load merge: walk from oldest to youngest so later entries overwrite lanes.
   // The head being retired this cycle is still valid here, which is intended:
   // memory only commits it at the edge, so mem_rdata does not yet contain it.
   always_comb begin : merge_blk
      logic [PTR_W-1:0] idx;
      merged = mem_rdata;
      idx    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (valid_q[idx] && (addr_q[idx] == ALUResult[31:2])) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (be_q[idx][b]) begin
                  merged[8*b +: 8] = data_q[idx][8*b +: 8];
               end
            end
         end
      end
   end

   assign ReadData  = merged;
   assign mem_raddr = ALUResult[31:2];

   // Drain side depends only on registered state.
   assign mem_req   = not_empty;
   assign mem_addr  = addr_q[head_q];
   assign mem_wdata = data_q[head_q];
   assign mem_be    = be_q[head_q];

   assign stall_o   = full;
   assign overflow  = overflow_q;
   assign count     = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Testbench for dmem_write_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based reference model. Drained writes
// are checked by a separate monitor against a scoreboard of expected writes.
module tb_dmem_write_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   logic             clk;
   logic             reset;
   logic             MemWrite;
   logic [31:0]      ALUResult;
   logic [31:0]      WriteData;
   logic [3:0]       ByteEn;
   logic [31:0]      ReadData;
   logic [29:0]      mem_raddr;
   logic [31:0]      mem_rdata;
   logic             mem_req;
   logic [29:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_ack;
   logic             stall_o;
   logic             overflow;
   logic [CNT_W-1:0] count;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t model_q[$];   // reference buffer contents, oldest first
   ent_t exp_q[$];     // scoreboard of writes expected on mem_*
   bit   ovf_m;

   dmem_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ByteEn    (ByteEn),
      .ReadData  (ReadData),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .stall_o   (stall_o),
      .overflow  (overflow),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the load-merge rule: overlay pending bytes oldest to youngest.
   function automatic logic [31:0] model_read(input logic [29:0] wa, input logic [31:0] rd);
      logic [31:0] r;
      r = rd;
      foreach (model_q[k]) begin
         if (model_q[k].a == wa) begin
            for (int b = 0; b < 4; b++) begin
               if (model_q[k].be[b]) r[8*b +: 8] = model_q[k].d[8*b +: 8];
            end
         end
      end
      return r;
   endfunction

   // One clock: drive at negedge, check outputs, then advance the model to
   // what must be true after the coming rising edge.
   task automatic cycle(input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit ack, input logic [31:0] rdata);
      bit   ret;
      bit   enq;
      ent_t e;
      @(negedge clk);
      MemWrite  = mw;
      ALUResult = addr;
      WriteData = wd;
      ByteEn    = be;
      mem_ack   = ack;
      mem_rdata = rdata;
      #2;
      chk("count", 32'(count), 32'(model_q.size()));
      chk("stall_o", 32'(stall_o), (model_q.size() == DEPTH) ? 32'd1 : 32'd0);
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("mem_req", 32'(mem_req), (model_q.size() != 0) ? 32'd1 : 32'd0);
      chk("mem_raddr", 32'(mem_raddr), 32'(addr[31:2]));
      chk("read_data", ReadData, model_read(addr[31:2], rdata));
      if (model_q.size() != 0) begin
         chk("head_addr", 32'(mem_addr), 32'(model_q[0].a));
         chk("head_data", mem_wdata, model_q[0].d);
         chk("head_be", 32'(mem_be), 32'(model_q[0].be));
      end
      ret = (model_q.size() != 0) && ack;
      enq = mw && (be != 4'b0) && ((model_q.size() < DEPTH) || ret);
      if (mw && (be != 4'b0) && (model_q.size() == DEPTH) && !ret) ovf_m = 1'b1;
      if (ret) void'(model_q.pop_front());
      if (enq) begin
         e.a  = addr[31:2];
         e.d  = wd;
         e.be = be;
         model_q.push_back(e);
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input bit ack);
      cycle(1'b0, 32'h0, 32'h0, 4'h0, ack, $urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      MemWrite = 1'b0;
      mem_ack  = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      model_q.delete();
      exp_q.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && model_q.size() != 0; i++) idle(1'b1);
      chk("drain_done", 32'(model_q.size()), 32'd0);
   endtask

   // Monitor: each accepted write must be the next one expected.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #1;
         if (reset && mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
               chk("drain_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("drain_addr", 32'(mem_addr), 32'(e.a));
               chk("drain_data", mem_wdata, e.d);
               chk("drain_be", 32'(mem_be), 32'(e.be));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      ByteEn    = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      ovf_m     = 1'b0;
      do_reset();

      // Single store then ack
      cycle(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
      chk("single_addr", 32'(mem_addr), 32'h40);
      chk("single_data", mem_wdata, 32'hAABBCCDD);
      idle(1'b0);
      chk("single_empty", 32'(count), 32'd0);

      // ByteEn=0 store is a no-op
      cycle(1'b1, 32'h200, 32'h12345678, 4'h0, 1'b0, 32'h0);
      idle(1'b0);
      chk("be0_noop", 32'(count), 32'd0);

      // Fill to full, overflow, then enqueue+retire while full
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(i * 4), $urandom, 4'hF, 1'b0, 32'h0);
      cycle(1'b1, 32'h400, 32'hDEAD0000, 4'hF, 1'b0, 32'h0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_stall", 32'(stall_o), 32'd1);
      cycle(1'b1, 32'h404, 32'hBEEF0000, 4'hF, 1'b1, 32'h0);
      chk("ovf_set", 32'(overflow), 32'd1);
      idle(1'b0);
      chk("full_swap_count", 32'(count), 32'd4);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      drain();
      idle(1'b0);
      chk("stall_drop", 32'(stall_o), 32'd0);

      // Reset mid-drain
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(i * 4), $urandom, 4'hF, 1'b0, 32'h0);
      idle(1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Byte merge
      cycle(1'b1, 32'h100, 32'h000000EE, 4'b0001, 1'b0, 32'h0);
      cycle(1'b1, 32'h100, 32'h0000FF00, 4'b0010, 1'b0, 32'h0);
      cycle(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h11223344);
      chk("merge_bytes", ReadData, 32'h1122FFEE);
      drain();

      // Youngest wins, non-matching word reads memory
      cycle(1'b1, 32'h100, 32'h00000001, 4'b0001, 1'b0, 32'h0);
      cycle(1'b1, 32'h100, 32'h00000002, 4'b0001, 1'b0, 32'h0);
      cycle(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hCAFEBABE);
      chk("youngest_wins", 32'(ReadData[7:0]), 32'h02);
      cycle(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, 32'h5A5A5A5A);
      chk("no_match", ReadData, 32'h5A5A5A5A);
      // Retiring head is still merged; same-cycle store is not
      cycle(1'b1, 32'h100, 32'h00000077, 4'b0001, 1'b1, 32'h0);
      chk("retire_merge", 32'(ReadData[7:0]), 32'h02);
      drain();

      // Throughput with continuous acks
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h600 + 32'(i * 4), $urandom, 4'hF, 1'b1, $urandom);
         chk("thru_cnt_le1", (count <= 1) ? 32'd1 : 32'd0, 32'd1);
         chk("thru_no_stall", 32'(stall_o), 32'd0);
      end
      drain();

      // Random traffic over a few words so merges and full/overflow occur
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         cycle($urandom_range(0, 9) < 6,
               32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 9) < 4, $urandom);
      end
      drain();
      idle(1'b0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
